// File: rtl/arb_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_capture_pkg
// Purpose  : Shared types and helpers for the arbitrated capture register.
//            - state_t : output buffer occupancy (EMPTY / FULL)
//            - idx_w() : width of a source index, never less than 1 bit
// Revision : 1.0 - initial release
// ============================================================================
package arb_capture_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index width for n sources; a single source still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_capture_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Grants the first asserted
//            request at or after ptr, wrapping from N_SRC-1 back to 0.
// Ports    : req     in  N_SRC  request vector
//            ptr     in  IDX_W  highest-priority index this cycle
//            gnt     out N_SRC  one-hot grant (zero when no request)
//            gnt_idx out IDX_W  index of granted request (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import arb_capture_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int IDX_W = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [N_SRC-1:0] w_upper;
  logic [N_SRC-1:0] w_pick;

  // Requests at or above the pointer take priority; if none exist the
  // search wraps and the plain request vector is used instead.
  always_comb begin
    w_upper = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_upper[i] = req[i] && (i >= int'(ptr));
    end
  end

  assign w_pick = (|w_upper) ? w_upper : req;

  // Lowest set bit of the chosen vector is the winner.
  assign gnt = w_pick & (~w_pick + N_SRC'(1));

  always_comb begin
    gnt_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_pick[i]) gnt_idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_capture_reg.sv
`default_nettype none
// ============================================================================
// Module   : arb_capture_reg
// Purpose  : Single-clock capture register written by N_SRC producers through
//            a round-robin arbiter, presented to one consumer as a one-entry
//            valid/ready buffer. Drain and refill may happen in the same cycle.
// Ports    : clk       in  1            rising-edge clock
//            reset_n   in  1            asynchronous active-low reset
//            src_valid in  N_SRC        per-source write request
//            src_data  in  N_SRC*WIDTH  source i data at [i*WIDTH +: WIDTH]
//            src_ready out N_SRC        one-hot-or-zero accept (combinational)
//            q         out WIDTH        captured data
//            q_valid   out 1            q holds unconsumed data
//            q_ready   in  1            consumer takes q this cycle
//            grant_id  out IDX_W        source that wrote the current q
//            coll_cnt  out CNT_W        saturating collision count
//                                       (only with ARB_COLL_CNT_EN)
// Config   : ARB_COLL_CNT_EN - when defined, adds coll_cnt and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module arb_capture_reg
  import arb_capture_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N_SRC = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*WIDTH-1:0]   src_data,
  output logic [N_SRC-1:0]         src_ready,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [idx_w(N_SRC)-1:0]  grant_id
`ifdef ARB_COLL_CNT_EN
  ,
  output logic [CNT_W-1:0]         coll_cnt
`endif
);

  localparam int IDX_W = idx_w(N_SRC);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] r_rr_ptr;

  logic [N_SRC-1:0] w_gnt;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_can_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_win_data;
  logic [IDX_W-1:0] w_ptr_next;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (src_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Buffer can take a new word when empty, or when the consumer is draining
  // it this cycle. Held-off while reset is asserted so no source sees an
  // accept that the register would then discard.
  assign w_can_load = reset_n && ((r_state == EMPTY) || q_ready);
  assign src_ready  = w_gnt & {N_SRC{w_can_load}};
  assign w_accept   = |(src_valid & src_ready);

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt[i]) w_win_data = src_data[i*WIDTH +: WIDTH];
    end
  end

  // Pointer moves just past the winner so that source drops to lowest priority.
  assign w_ptr_next = (w_gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_q        <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_state    <= FULL;
        r_q        <= w_win_data;
        r_grant_id <= w_gnt_idx;
        r_rr_ptr   <= w_ptr_next;
      end else if ((r_state == FULL) && q_ready) begin
        r_state <= EMPTY;
      end
    end
  end

  assign q        = r_q;
  assign q_valid  = (r_state == FULL);
  assign grant_id = r_grant_id;

`ifdef ARB_COLL_CNT_EN
  logic [CNT_W-1:0] r_coll_cnt;
  logic             w_multi;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi = |(src_valid & (src_valid - N_SRC'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coll_cnt <= '0;
    end else if (w_multi && (r_coll_cnt != {CNT_W{1'b1}})) begin
      r_coll_cnt <= r_coll_cnt + CNT_W'(1);
    end
  end

  assign coll_cnt = r_coll_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb_capture_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_capture_reg
// Purpose  : Self-checking bench for arb_capture_reg (WIDTH=8, N_SRC=3,
//            CNT_W=2). A behavioural model tracks buffer occupancy, the
//            round-robin pointer and the expected contents; a compare process
//            checks all outputs every cycle. Directed sequences with literal
//            expectations are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_capture_reg;

  localparam int WIDTH = 8;
  localparam int N_SRC = 3;
  localparam int CNT_W = 2;
  localparam int IDX_W = 2;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b1;
  logic [N_SRC-1:0]       src_valid = '0;
  logic [N_SRC*WIDTH-1:0] src_data = '0;
  logic                   q_ready = 1'b0;
  logic [N_SRC-1:0]       src_ready;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [IDX_W-1:0]       grant_id;
`ifdef ARB_COLL_CNT_EN
  logic [CNT_W-1:0]       coll_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_capture_reg #(
    .WIDTH (WIDTH),
    .N_SRC (N_SRC),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .grant_id  (grant_id)
`ifdef ARB_COLL_CNT_EN
    ,
    .coll_cnt  (coll_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requesting source at or after ptr, scanning with modular wrap.
  function automatic int pick(input logic [N_SRC-1:0] v, input int ptr);
    for (int k = 0; k < N_SRC; k++) begin
      if (v[(ptr + k) % N_SRC]) return (ptr + k) % N_SRC;
    end
    return -1;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit               m_full;
  logic [WIDTH-1:0] m_q;
  int               m_gid;
  int               m_ptr;
  int               m_cnt;
  int               m_win;
  logic [N_SRC-1:0] m_ready;
  logic [N_SRC-1:0] acc_last = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_full = 1'b0;
        m_q    = '0;
        m_gid  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
      end
      m_win   = pick(src_valid, m_ptr);
      m_ready = '0;
      if (reset_n && (m_win >= 0) && (!m_full || q_ready)) m_ready[m_win] = 1'b1;

      chk("m_src_ready", 32'(src_ready), 32'(m_ready));
      chk("m_q_valid",   32'(q_valid),   32'(m_full));
      chk("m_q",         32'(q),         32'(m_q));
      chk("m_grant_id",  32'(grant_id),  32'(m_gid));
`ifdef ARB_COLL_CNT_EN
      chk("m_coll_cnt",  32'(coll_cnt),  32'(m_cnt));
`endif
      acc_last = src_valid & src_ready;

      if (reset_n) begin
        if (($countones(src_valid) >= 2) && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
        if (m_ready != '0) begin
          m_full = 1'b1;
          m_q    = src_data[m_win*WIDTH +: WIDTH];
          m_gid  = m_win;
          m_ptr  = (m_win + 1) % N_SRC;
        end else if (m_full && q_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_gid[5];
    int exp_cnt[5];
    exp_gid = '{0, 1, 0, 1, 0};
    exp_cnt = '{1, 2, 3, 3, 3};

    // Reset with two sources requesting.
    #1 reset_n = 1'b0;
    src_valid = 3'b011;
    src_data  = {8'h00, 8'h01, 8'h00};
    repeat (3) step();
    chk("rst_q",         32'(q),         32'h0);
    chk("rst_q_valid",   32'(q_valid),   32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    chk("rst_grant_id",  32'(grant_id),  32'h0);
`ifdef ARB_COLL_CNT_EN
    chk("rst_coll_cnt",  32'(coll_cnt),  32'h0);
`endif

    // Alternating grants with both sources valid and consumer always ready.
    reset_n = 1'b1;
    q_ready = 1'b1;
    #1 chk("rr_first_ready", 32'(src_ready), 32'b001);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_grant_id", 32'(grant_id), 32'(exp_gid[k]));
      chk("rr_q",        32'(q),        32'(exp_gid[k]));
      chk("rr_q_valid",  32'(q_valid),  32'h1);
`ifdef ARB_COLL_CNT_EN
      chk("coll_cnt_sat", 32'(coll_cnt), 32'(exp_cnt[k]));
`endif
    end

    // Back-pressure: buffer full, consumer stalled, source 1 waiting.
    q_ready   = 1'b0;
    src_valid = 3'b010;
    #1 chk("stall_ready", 32'(src_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_q",        32'(q),         32'h00);
      chk("stall_grant_id", 32'(grant_id),  32'h0);
      chk("stall_q_valid",  32'(q_valid),   32'h1);
      chk("stall_ready",    32'(src_ready), 32'h0);
    end

    // Drain and refill in one cycle: waiting source 1 gets in.
    q_ready = 1'b1;
    #1 chk("refill_ready", 32'(src_ready), 32'b010);
    step();
    chk("refill_q",        32'(q),        32'h01);
    chk("refill_grant_id", 32'(grant_id), 32'h1);
    chk("refill_q_valid",  32'(q_valid),  32'h1);

    // Drain and refill again from source 0.
    src_valid       = 3'b001;
    src_data[7:0]   = 8'h5A;
    step();
    chk("refill0_q",        32'(q),        32'h5A);
    chk("refill0_grant_id", 32'(grant_id), 32'h0);
    chk("refill0_q_valid",  32'(q_valid),  32'h1);

    // Asynchronous reset mid-cycle while full.
    src_valid = 3'b000;
    q_ready   = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_q_valid",  32'(q_valid),  32'h0);
    chk("async_q",        32'(q),        32'h0);
    chk("async_grant_id", 32'(grant_id), 32'h0);
`ifdef ARB_COLL_CNT_EN
    chk("async_coll_cnt", 32'(coll_cnt), 32'h0);
`endif
    step();
    reset_n            = 1'b1;
    src_valid          = 3'b101;
    src_data[23:16]    = 8'hC3;
    // Pointer back at 0 selects source 0 over source 2.
    #1 chk("ptr_after_reset", 32'(src_ready), 32'b001);
    step();
    chk("post_reset_q",        32'(q),        32'h5A);
    chk("post_reset_grant_id", 32'(grant_id), 32'h0);

    // Randomized traffic; sources hold their request until accepted.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!src_valid[i] || acc_last[i]) begin
          src_valid[i]              = ($urandom_range(0, 99) < 60);
          src_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      q_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end

    src_valid = '0;
    q_ready   = 1'b1;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
